// File: rtl/bnn_pkg.sv
// Shared definitions for the binary-neuron datapath: FSM state encoding and
// the popcount result width used by both the accumulator and the activation stage.
package bnn_pkg;

    localparam logic [0:0] ACC = 1'b0;
    localparam logic [0:0] OUT = 1'b1;

    // Bits needed to count 0..in_w matches.
    function automatic int unsigned pc_width(input int unsigned in_w);
        return $clog2(in_w + 1);
    endfunction

endpackage

// File: rtl/bnn_popcount.sv
// Combinational XNOR-popcount of one beat: number of bit positions where x equals w.
module bnn_popcount
    import bnn_pkg::*;
#(
    parameter int unsigned IN_W = 8,
    localparam int unsigned PC_W = pc_width(IN_W)
) (
    input  logic [IN_W-1:0] x,
    input  logic [IN_W-1:0] w,
    output logic [PC_W-1:0] pc
);

    logic [IN_W-1:0] match;

    assign match = ~(x ^ w);

    always_comb begin
        pc = '0;
        for (int i = 0; i < IN_W; i++) begin
            pc = pc + PC_W'(match[i]);
        end
    end

endmodule

// File: rtl/bnn_xnor_acc.sv
// Streaming XNOR-popcount accumulator for one binary neuron; out_sum feeds the threshold stage.
// Define BNN_ACC_SAT_EN to clamp the sum at 2^ACC_W-1 instead of wrapping.
module bnn_xnor_acc
    import bnn_pkg::*;
#(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned ACC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [IN_W-1:0]  in_x,
    input  logic [IN_W-1:0]  in_w,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);

    localparam int unsigned PC_W = pc_width(IN_W);

    logic [0:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic             out_ovf_q, out_ovf_d;

    logic [PC_W-1:0]  pc;
    logic [ACC_W:0]   sum_ext;
    logic             carry;
    logic             ovf_new;
    logic [ACC_W-1:0] acc_new;
    logic             beat;

    bnn_popcount #(
        .IN_W (IN_W)
    ) u_popcount (
        .x  (in_x),
        .w  (in_w),
        .pc (pc)
    );

    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == OUT);
    assign out_sum   = sum_q;
    assign out_ovf   = out_ovf_q;

    assign beat = in_valid && in_ready;

    // One extra bit so the carry out of the accumulator is visible.
    assign sum_ext = {1'b0, acc_q} + (ACC_W + 1)'(pc);
    assign carry   = sum_ext[ACC_W];
    assign ovf_new = ovf_q | carry;

`ifdef BNN_ACC_SAT_EN
    // Once overflowed, the sum stays pinned at full scale for the rest of the vector.
    assign acc_new = ovf_new ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    assign acc_new = sum_ext[ACC_W-1:0];
`endif

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        sum_d     = sum_q;
        out_ovf_d = out_ovf_q;
        unique case (state_q)
            ACC: begin
                if (beat) begin
                    if (in_last) begin
                        sum_d     = acc_new;
                        out_ovf_d = ovf_new;
                        state_d   = OUT;
                    end else begin
                        acc_d = acc_new;
                        ovf_d = ovf_new;
                    end
                end
            end
            OUT: begin
                if (out_ready) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ACC;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            sum_q     <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            sum_q     <= sum_d;
            out_ovf_q <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_bnn_xnor_acc.sv
// Self-checking bench for bnn_xnor_acc (IN_W=8, ACC_W=8) with a result scoreboard.
module tb_bnn_xnor_acc;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       in_last;
    logic [7:0] in_x;
    logic [7:0] in_w;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic       out_ovf;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] sum;
        logic       ovf;
    } res_t;

    res_t       sb[$];
    logic [7:0] m_acc = '0;
    logic       m_ovf = 1'b0;

    always #5 clk = ~clk;

    bnn_xnor_acc #(
        .IN_W  (8),
        .ACC_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .in_x      (in_x),
        .in_w      (in_w),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf)
    );

    // Reference model: applied for each accepted beat.
    task automatic model_beat(input logic [7:0] x, input logic [7:0] w, input logic last);
        logic [8:0] s;
        logic [3:0] pc;
        logic       ovf_n;
        logic [7:0] acc_n;
        pc = 0;
        for (int i = 0; i < 8; i++) if (x[i] == w[i]) pc++;
        s = {1'b0, m_acc} + {5'd0, pc};
        ovf_n = m_ovf | s[8];
`ifdef BNN_ACC_SAT_EN
        acc_n = ovf_n ? 8'hFF : s[7:0];
`else
        acc_n = s[7:0];
`endif
        if (last) begin
            sb.push_back('{sum: acc_n, ovf: ovf_n});
            m_acc = '0;
            m_ovf = 1'b0;
        end else begin
            m_acc = acc_n;
            m_ovf = ovf_n;
        end
    endtask

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic send_beat(input logic [7:0] x, input logic [7:0] w, input logic last);
        bit ok = 0;
        in_valid = 1'b1;
        in_x     = x;
        in_w     = w;
        in_last  = last;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_beat_timeout in_ready=%0b required 1", in_ready);
        end else begin
            @(posedge clk);
            model_beat(x, w, last);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out_valid(input string name);
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s out_valid_timeout got %0b required 1", name, out_valid);
        end
    endtask

    // At a negedge with out_valid high: compare, handshake, check bubble.
    task automatic take_result(input string name);
        res_t exp;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard_empty got sum=%0d required an expected entry", name,
                     out_sum);
            return;
        end
        exp = sb.pop_front();
        checks++;
        if (out_sum !== exp.sum) begin
            errors++;
            $display("FAIL %s out_sum got %0d required %0d", name, out_sum, exp.sum);
        end
        checks++;
        if (out_ovf !== exp.ovf) begin
            errors++;
            $display("FAIL %s out_ovf got %0b required %0b", name, out_ovf, exp.ovf);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s after_handshake got valid=%0b ready=%0b required valid=0 ready=1",
                     name, out_valid, in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 8'd0 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset got ready=%0b valid=%0b sum=%0d ovf=%0b required 1 0 0 0",
                     in_ready, out_valid, out_sum, out_ovf);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_one_beat();
        send_beat(8'hFF, 8'hFF, 1'b1);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL one_beat_latency got valid=%0b ready=%0b required valid=1 ready=0",
                     out_valid, in_ready);
        end
        checks++;
        if (out_sum !== 8'd8) begin
            errors++;
            $display("FAIL one_beat_sum got %0d required 8", out_sum);
        end
        take_result("one_beat");
    endtask

    task automatic test_multi_beat_backpressure();
        logic [7:0] held;
        send_beat(8'h0F, 8'h00, 1'b0);
        send_beat(8'hAA, 8'h55, 1'b0);
        send_beat(8'h3C, 8'h3C, 1'b1);
        wait_out_valid("multi_beat");
        checks++;
        if (out_sum !== 8'd12 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL multi_beat got sum=%0d ovf=%0b required 12 0", out_sum, out_ovf);
        end
        held = out_sum;
        // Present a beat that must be ignored while the result is pending.
        in_valid = 1'b1;
        in_x     = 8'hFF;
        in_w     = 8'hFF;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== held) begin
                errors++;
                $display("FAIL backpressure cyc%0d got valid=%0b ready=%0b sum=%0d required 1 0 %0d",
                         i, out_valid, in_ready, out_sum, held);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        take_result("backpressure");
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 33; i++) send_beat(8'hFF, 8'hFF, i == 33);
        wait_out_valid("overflow");
        checks++;
`ifdef BNN_ACC_SAT_EN
        if (out_sum !== 8'd255 || out_ovf !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sat got sum=%0d ovf=%0b required 255 1", out_sum, out_ovf);
        end
`else
        if (out_sum !== 8'd8 || out_ovf !== 1'b1) begin
            errors++;
            $display("FAIL overflow_wrap got sum=%0d ovf=%0b required 8 1", out_sum, out_ovf);
        end
`endif
        take_result("overflow");
    endtask

    task automatic test_reset_mid();
        send_beat(8'hFF, 8'hFF, 1'b0);
        send_beat(8'hFF, 8'hFF, 1'b0);
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_sum !== 8'd0 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got valid=%0b sum=%0d ovf=%0b required 0 0 0",
                     out_valid, out_sum, out_ovf);
        end
        m_acc = '0;
        m_ovf = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        // Reset while a result is pending must drop it asynchronously.
        send_beat(8'hFF, 8'h00, 1'b1);
        wait_out_valid("reset_in_out");
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_sum !== 8'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_out got valid=%0b sum=%0d ready=%0b required 0 0 1",
                     out_valid, out_sum, in_ready);
        end
        void'(sb.pop_front());
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_beat(8'hF0, 8'h0F, 1'b1);
        wait_out_valid("post_reset_a");
        take_result("post_reset_a");
        send_beat(8'h81, 8'h81, 1'b1);
        wait_out_valid("post_reset_b");
        checks++;
        if (out_sum !== 8'd8) begin
            errors++;
            $display("FAIL post_reset_b_sum got %0d required 8", out_sum);
        end
        take_result("post_reset_b");
    endtask

    task automatic test_back_to_back();
        send_beat(8'hF0, 8'h00, 1'b1);
        wait_out_valid("b2b_first");
        in_valid = 1'b1;
        in_x     = 8'h00;
        in_w     = 8'h00;
        in_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL b2b_hold cyc%0d got ready=%0b valid=%0b required 0 1",
                         i, in_ready, out_valid);
            end
        end
        checks++;
        if (out_sum !== 8'd4) begin
            errors++;
            $display("FAIL b2b_first_sum got %0d required 4", out_sum);
        end
        void'(sb.pop_front());
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_bubble got ready=%0b valid=%0b required 1 0", in_ready, out_valid);
        end
        @(posedge clk);
        model_beat(8'h00, 8'h00, 1'b1);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_out_valid("b2b_second");
        take_result("b2b_second");
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_x      = '0;
        in_w      = '0;
        out_ready = 1'b0;
        test_reset();
        test_one_beat();
        test_multi_beat_backpressure();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d entries required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
